mpu6050_seq_ctrl: RTL
=====================

Name: mpu6050_seq_ctrl

Overview:
- Transaction scheduler in front of the single-master I2C byte driver for the MPU-6050.
- After reset it plays a fixed 3-entry init write table: PWR_MGMT_1, ACCEL_CONFIG, GYRO_CONFIG.
- It then issues a 6-byte gyro burst read (start reg 0x43) every SAMPLE_DIV cycles and presents the result as three signed 16-bit words with a valid strobe.
- It supervises each transaction with a timeout and retry, and latches a sticky error flag.

Parameters:
- SAMPLE_DIV, 3000, clk cycles between burst-read launches (measured launch-to-launch); min 16.
- TIMEOUT_CYC, 4096, max cycles from run_req rise to end_flag before the transaction is aborted.
- MAX_RETRY, 3, retries per transaction after a timeout before entering ERROR.
- ACCEL_CFG, 8'h08, value written to reg 0x1C.
- GYRO_CFG, 8'h00, value written to reg 0x1B.

Ports:
- clk  in  1  system clock, the driver's clock domain.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  level; 0 holds the block in IDLE once any in-flight transaction finishes.
- run_req  out  1  request to the driver; level, held until end_flag.
- r_en  out  1  1 = read transaction, 0 = write.
- reg_addr  out  8  register address.
- wdata  out  8  write byte.
- num_data  out  3  byte count.
- end_flag  in  1  driver completion pulse (1 cycle).
- rdata  in  64  received bytes; byte k = rdata[8k+7:8k], byte 0 = first byte on the bus.
- gyro_x, gyro_y, gyro_z  out  16  signed samples, {byte0,byte1}, {byte2,byte3}, {byte4,byte5}.
- sample_valid  out  1  one-cycle pulse when gyro_* update.
- init_done  out  1  level; set after the last init write completes.
- err  out  1  sticky; cleared only by reset.

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0: run_req, r_en, reg_addr, wdata, num_data, gyro_*, sample_valid, init_done, err. Init index, retry count and both timers also 0.

State machine:
- IDLE -> INIT_REQ when enable=1.
- INIT_REQ:
  - Drive r_en=0, num_data=1, reg_addr/wdata from table[idx], run_req=1.
  - Go to WAIT with ret_state=INIT.
- WAIT:
  - Operands and run_req held stable; timeout counter increments each cycle.
  - On end_flag=1: drop run_req next cycle, clear retry count, go to GAP.
  - On timeout with no end_flag: drop run_req.
    - If retry < MAX_RETRY: retry++, go to GAP, then reissue the same transaction.
    - Otherwise: set err, go to ERROR.
- GAP:
  - Exactly 1 cycle with run_req=0; mandatory between any two requests.
  - Then, if ret_state=INIT: idx++. If idx reaches 3, set init_done and go to READ_REQ; else go to INIT_REQ.
  - If ret_state=READ: go to PERIOD.
- READ_REQ:
  - Drive r_en=1, reg_addr=8'h43, num_data=3'd6, wdata=0, run_req=1.
  - Restart the sample timer here; go to WAIT with ret_state=READ.
- On a successful READ end_flag:
  - Capture rdata into gyro_* in the same cycle.
  - Pulse sample_valid on the following cycle.
- PERIOD:
  - Wait until the sample timer reaches SAMPLE_DIV-1, then go to READ_REQ.
  - If a read overruns SAMPLE_DIV, the next read launches immediately after GAP. Periods are skipped, never queued.
- enable=0 observed in READ_REQ or PERIOD: go to IDLE, keeping init_done=1. Re-enable resumes at READ_REQ; no re-init.
- enable=0 in WAIT has no effect until the transaction ends.
- ERROR: terminal. run_req stays 0 until reset.
- end_flag arriving in the same cycle the timeout fires counts as success.
- end_flag outside WAIT is ignored.
- Timeout counter width: clog2(TIMEOUT_CYC+1). Sample timer width: clog2(SAMPLE_DIV). Neither counter wraps; both saturate or reset per the states above.

Decomposition:
- Package mpu6050_pkg holds:
  - state enum;
  - register address constants (PWR_MGMT_1=8'h6B, ACCEL_CONFIG=8'h1C, GYRO_CONFIG=8'h1B, GYRO_XOUT_H=8'h43);
  - a struct {addr, data} for the init table entry;
  - the init table as a constant function of the parameters.
- One sub-module, seq_watchdog: a loadable down-counter with start/clear/expired. It is instantiated twice, for the timeout and the sample period.

Test Plan:
- Init sequence: reset, then enable=1 with a driver model returning end_flag 20 cycles after each request. Expect writes (6B,00), (1C,08), (1B,00) in order, each with r_en=0 and num_data=1. Expect a ≥1-cycle run_req low gap between them, and init_done high after the third.
- Burst read: model returns rdata=64'h0000_FF80_0102_7FFF. Expect gyro_x=16'hFF7F, gyro_y=16'h0201, gyro_z=16'h80FF, and sample_valid pulsed once.
- Period: SAMPLE_DIV=100, end_flag latency 30. Read launches are exactly 100 cycles apart over 5 samples. With latency 150, launches occur at end+2 cycles with no back-to-back queueing.
- Timeout/retry: suppress end_flag on the 2nd init write for 2 attempts, then respond. Expect 3 issues of (1C,08), no err, and init completing.
- Error: never return end_flag, MAX_RETRY=3. Expect 4 attempts spaced TIMEOUT_CYC+1 apart, then err=1 and run_req held 0 for 10k cycles.
- Reset mid-read: assert rst_n=0 during WAIT. All outputs are 0 immediately (async). After release with enable=1, the init table replays from entry 0.

Source files
------------

// File: rtl/mpu6050_pkg.sv
// mpu6050_pkg: shared types, MPU-6050 register map and the init write table.
//   state_t       sequencer states
//   init_entry_t  one init write {addr, data}
//   init_table()  builds the init table from the configuration bytes
package mpu6050_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT_REQ,
        S_WAIT,
        S_GAP,
        S_READ_REQ,
        S_PERIOD,
        S_ERROR
    } state_t;

    localparam logic [7:0] PWR_MGMT_1   = 8'h6B;
    localparam logic [7:0] ACCEL_CONFIG = 8'h1C;
    localparam logic [7:0] GYRO_CONFIG  = 8'h1B;
    localparam logic [7:0] GYRO_XOUT_H  = 8'h43;

    localparam int INIT_LEN = 3;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } init_entry_t;

    // Four slots so a 2-bit index never selects outside the array; slot 3 is unused.
    typedef init_entry_t [3:0] init_table_t;

    function automatic init_table_t init_table(input logic [7:0] accel_cfg, input logic [7:0] gyro_cfg);
        init_table_t t;
        t[0] = {PWR_MGMT_1, 8'h00};
        t[1] = {ACCEL_CONFIG, accel_cfg};
        t[2] = {GYRO_CONFIG, gyro_cfg};
        t[3] = '0;
        return t;
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// seq_watchdog: loadable saturating down-counter.
//   start   load `load` and arm
//   clear   disarm and zero
//   expired armed and count has reached zero (stays high until start/clear)
module seq_watchdog #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         clear,
    input  logic [W-1:0] load,
    output logic         expired
);

    logic [W-1:0] cnt;
    logic         run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            run <= 1'b0;
        end else if (start) begin
            cnt <= load;
            run <= 1'b1;
        end else if (clear) begin
            cnt <= '0;
            run <= 1'b0;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = run && cnt == '0;

endmodule

// File: rtl/mpu6050_seq_ctrl.sv
// mpu6050_seq_ctrl: init-write then periodic gyro burst-read scheduler for an I2C byte driver.
//   clk, rst_n                  clock, async active-low reset
//   enable                      run/hold level
//   run_req, r_en, reg_addr,
//   wdata, num_data             request to the driver, held until end_flag
//   end_flag, rdata             driver completion pulse and received bytes
//   gyro_x/y/z, sample_valid    big-endian gyro samples and their update strobe
//   init_done, err              init finished; sticky transaction failure
module mpu6050_seq_ctrl
    import mpu6050_pkg::*;
#(
    parameter int         SAMPLE_DIV  = 3000,
    parameter int         TIMEOUT_CYC = 4096,
    parameter int         MAX_RETRY   = 3,
    parameter logic [7:0] ACCEL_CFG   = 8'h08,
    parameter logic [7:0] GYRO_CFG    = 8'h00
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    output logic               run_req,
    output logic               r_en,
    output logic [7:0]         reg_addr,
    output logic [7:0]         wdata,
    output logic [2:0]         num_data,
    input  logic               end_flag,
    input  logic [63:0]        rdata,
    output logic signed [15:0] gyro_x,
    output logic signed [15:0] gyro_y,
    output logic signed [15:0] gyro_z,
    output logic               sample_valid,
    output logic               init_done,
    output logic               err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int SW = $clog2(SAMPLE_DIV);
    localparam int RW = $clog2(MAX_RETRY + 2);
    // Loads are two short of the period: one cycle for the load edge, one for the
    // decision cycle that sees expired, so the launch-to-launch distance is exact.
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYC - 2);
    localparam logic [SW-1:0] SMP_LOAD = SW'(SAMPLE_DIV - 2);
    localparam logic [RW-1:0] MAX_R    = RW'(MAX_RETRY);
    localparam logic [1:0]    LAST_IDX = 2'(INIT_LEN - 1);
    localparam init_table_t   TBL      = init_table(ACCEL_CFG, GYRO_CFG);

    state_t        state, nxt;
    logic          ret_rd;
    logic [1:0]    idx;
    logic [RW-1:0] retry;
    logic          tmo_start, tmo_clear, tmo_exp;
    logic          smp_start, smp_clear, smp_exp;
    logic          done, fail, init_step;
    logic          active, rd;
    logic          unused_rdata;

    assign unused_rdata = ^rdata[63:48];

    seq_watchdog #(.W(TW)) u_tmo (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (tmo_start),
        .clear   (tmo_clear),
        .load    (TMO_LOAD),
        .expired (tmo_exp)
    );

    seq_watchdog #(.W(SW)) u_smp (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (smp_start),
        .clear   (smp_clear),
        .load    (SMP_LOAD),
        .expired (smp_exp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= nxt;
    end

    // In GAP a nonzero retry count means the last attempt timed out and must be reissued.
    always_comb begin
        nxt       = state;
        tmo_start = 1'b0;
        tmo_clear = 1'b0;
        smp_start = 1'b0;
        smp_clear = 1'b0;
        done      = 1'b0;
        fail      = 1'b0;
        init_step = 1'b0;
        case (state)
            S_IDLE: begin
                smp_clear = 1'b1;
                nxt = !enable ? S_IDLE : init_done ? S_READ_REQ : S_INIT_REQ;
            end
            S_INIT_REQ: begin
                tmo_start = 1'b1;
                nxt = S_WAIT;
            end
            S_READ_REQ: begin
                tmo_start = enable;
                smp_start = enable;
                nxt = enable ? S_WAIT : S_IDLE;
            end
            S_WAIT: begin
                done = end_flag;
                fail = !end_flag && tmo_exp;
                nxt = done ? S_GAP : !fail ? S_WAIT : retry < MAX_R ? S_GAP : S_ERROR;
            end
            S_GAP: begin
                tmo_clear = 1'b1;
                init_step = retry == '0 && !ret_rd;
                nxt = retry != '0 ? (ret_rd ? S_READ_REQ : S_INIT_REQ) :
                      !ret_rd     ? (idx == LAST_IDX ? S_READ_REQ : S_INIT_REQ) :
                      (smp_exp && enable) ? S_READ_REQ : S_PERIOD;
            end
            S_PERIOD: nxt = !enable ? S_IDLE : smp_exp ? S_READ_REQ : S_PERIOD;
            default:  nxt = S_ERROR;
        endcase
    end

    // Request outputs decode from state so they drop the cycle after end_flag/timeout;
    // a READ_REQ seen with enable low never raises run_req.
    assign rd       = state == S_READ_REQ || (state == S_WAIT && ret_rd);
    assign active   = state == S_INIT_REQ || state == S_WAIT || (state == S_READ_REQ && enable);
    assign run_req  = active;
    assign r_en     = active && rd;
    assign reg_addr = !active ? 8'h00 : rd ? GYRO_XOUT_H : TBL[idx].addr;
    assign wdata    = (active && !rd) ? TBL[idx].data : 8'h00;
    assign num_data = !active ? 3'd0 : rd ? 3'd6 : 3'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ret_rd       <= 1'b0;
            idx          <= '0;
            retry        <= '0;
            err          <= 1'b0;
            init_done    <= 1'b0;
            sample_valid <= 1'b0;
            gyro_x       <= '0;
            gyro_y       <= '0;
            gyro_z       <= '0;
        end else begin
            if (state == S_INIT_REQ || state == S_READ_REQ) ret_rd <= state == S_READ_REQ;
            if (done) retry <= '0;
            else if (fail && retry < MAX_R) retry <= retry + 1'b1;
            if (fail && retry == MAX_R) err <= 1'b1;
            if (init_step) idx <= idx + 1'b1;
            if (init_step && idx == LAST_IDX) init_done <= 1'b1;
            sample_valid <= done && ret_rd;
            if (done && ret_rd) begin
                gyro_x <= {rdata[7:0],   rdata[15:8]};
                gyro_y <= {rdata[23:16], rdata[31:24]};
                gyro_z <= {rdata[39:32], rdata[47:40]};
            end
        end
    end

endmodule
